// File: rtl/boot_loader.sv
// ============================================================================
// boot_loader
// ----------------------------------------------------------------------------
// Copies the internal boot ROM (2^SIZE bytes) into SDRAM once the SDRAM
// controller reports ready, paced by the CPU clock enable. Once the copy has
// finished, HPS download writes are forwarded to SDRAM and the highest page
// touched by the download is tracked in romP.
//
// Ports
//   clock32 : system clock, every register updates on its rising edge
//   reset   : asynchronous, active-high reset
//   ready   : SDRAM controller initialised (low = not usable)
//   ce      : one-cycle pacing strobe (CPU clock enable)
//   romA    : boot ROM byte address
//   romQ    : boot ROM data, valid one cycle after romA
//   dlIo    : HPS download active
//   dlA     : HPS download byte address
//   dlD     : HPS download data
//   dlW     : HPS download write strobe
//   dlWait  : back-pressure to the HPS while the boot copy is not finished
//   sdrW    : SDRAM write request, one-cycle pulse
//   sdrA    : SDRAM byte address
//   sdrD    : SDRAM write data
//   romP    : highest 16 KB page holding ROM contents
//   busy    : boot copy in progress
//   done    : boot copy complete
// ============================================================================
module boot_loader #(
    parameter int SIZE = 17
) (
    input  logic            clock32,
    input  logic            reset,
    input  logic            ready,
    input  logic            ce,
    output logic [SIZE-1:0] romA,
    input  logic [7:0]      romQ,
    input  logic            dlIo,
    input  logic [21:0]     dlA,
    input  logic [7:0]      dlD,
    input  logic            dlW,
    output logic            dlWait,
    output logic            sdrW,
    output logic [21:0]     sdrA,
    output logic [7:0]      sdrD,
    output logic [7:0]      romP,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] cnt_next;
    logic            copy_write;
    logic            dl_write;

    // The ROM address is simply the byte counter; it is held stable through
    // FETCH and WRITE, so romQ has settled by the time WRITE sees its ce.
    assign romA   = cnt;
    assign dlWait = dlIo & ~done;

    // State and byte counter register.
    always_ff @(posedge clock32 or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. Losing ready before the copy has finished abandons
    // the copy entirely (no write issued) so that it restarts at byte 0.
    // Once in DONE the block never leaves it, and ce is ignored there.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        copy_write = 1'b0;
        dl_write   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_WAIT: begin
                cnt_next = '0;
                if (ready) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy = 1'b1;
                if (!ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else if (ce) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy = 1'b1;
                if (!ready) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else if (ce) begin
                    copy_write = 1'b1;
                    if (cnt == {SIZE{1'b1}}) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next   = cnt + SIZE'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (dlIo && dlW) begin
                    dl_write = 1'b1;
                end
            end
            default: begin
                state_next = ST_WAIT;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered SDRAM write port. Copy and download writes can never
    // coincide since they belong to different states. Address and data hold
    // their last value between pulses; romP follows every served download.
    always_ff @(posedge clock32 or posedge reset) begin
        if (reset) begin
            sdrW <= 1'b0;
            sdrA <= '0;
            sdrD <= '0;
            romP <= 8'h07;
        end else begin
            sdrW <= copy_write | dl_write;
            if (copy_write) begin
                sdrA <= 22'(cnt);
                sdrD <= romQ;
            end else if (dl_write) begin
                sdrA <= dlA;
                sdrD <= dlD;
                romP <= {2'b00, dlA[19:14]};
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// ============================================================================
// tb_boot_loader
// ----------------------------------------------------------------------------
// Directed bench for boot_loader with SIZE=4. The boot ROM is modelled as a
// synchronous memory where byte n reads 8'hA0+n, and ce pulses every
// 4 clocks. Outputs are sampled on the falling edge; inputs change on the
// falling edge (ce just after the rising edge).
// ============================================================================
module tb_boot_loader;

    localparam int SIZE = 4;

    logic            clock32 = 1'b0;
    logic            reset;
    logic            ready;
    logic            ce;
    logic [SIZE-1:0] romA;
    logic [7:0]      romQ;
    logic            dlIo;
    logic [21:0]     dlA;
    logic [7:0]      dlD;
    logic            dlW;
    logic            dlWait;
    logic            sdrW;
    logic [21:0]     sdrA;
    logic [7:0]      sdrD;
    logic [7:0]      romP;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;
    int last_ce;
    int last_writes;

    boot_loader #(.SIZE(SIZE)) dut (
        .clock32 (clock32),
        .reset   (reset),
        .ready   (ready),
        .ce      (ce),
        .romA    (romA),
        .romQ    (romQ),
        .dlIo    (dlIo),
        .dlA     (dlA),
        .dlD     (dlD),
        .dlW     (dlW),
        .dlWait  (dlWait),
        .sdrW    (sdrW),
        .sdrA    (sdrA),
        .sdrD    (sdrD),
        .romP    (romP),
        .busy    (busy),
        .done    (done)
    );

    // 10 ns system clock.
    always #5 clock32 = ~clock32;

    // Synchronous boot ROM: byte n holds 8'hA0 + n.
    always @(posedge clock32) begin
        romQ <= 8'hA0 + {4'h0, romA};
    end

    // Pacing strobe: one clock high out of every four.
    initial begin
        logic [1:0] phase;
        phase = 2'd0;
        ce    = 1'b0;
        forever begin
            @(posedge clock32);
            #1;
            phase = phase + 2'd1;
            ce    = (phase == 2'd0);
        end
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Presents one download write; returns on the falling edge just after
    // the rising edge that sampled it.
    task automatic applyStimulus(input logic [21:0] addr, input logic [7:0] data);
        dlA = addr;
        dlD = data;
        dlW = 1'b1;
        @(negedge clock32);
        dlW = 1'b0;
    endtask

    // Follows a copy until n_stop SDRAM writes are seen, checking each one
    // against the ROM contents in order. With spam set, dlW is held high
    // with a distinctive address so any forwarded download write shows up
    // as a wrong copy address.
    task automatic runCopy(input int n_stop, input bit spam);
        int idx;
        int ce_n;
        int cyc;
        idx  = 0;
        ce_n = 0;
        cyc  = 0;
        if (spam) begin
            dlA = 22'h3FFFFF;
            dlD = 8'h00;
            dlW = 1'b1;
        end
        while (idx < n_stop && cyc < 600) begin
            @(negedge clock32);
            cyc++;
            if (ce) ce_n++;
            if (sdrW) begin
                checkOutput("copy_addr", 32'(sdrA), 32'(idx));
                checkOutput("copy_data", 32'(sdrD), 32'(8'hA0 + idx));
                if (idx == 0) checkOutput("busy_mid", 32'(busy), 32'd1);
                idx++;
            end
        end
        dlW = 1'b0;
        if (idx < n_stop) checkOutput("copy_timeout", 32'(idx), 32'(n_stop));
        last_ce     = ce_n;
        last_writes = idx;
    endtask

    // Waits (bounded) for a falling edge at which ce is high.
    task automatic waitCe();
        int n;
        n = 0;
        @(negedge clock32);
        while (!ce && n < 10) begin
            @(negedge clock32);
            n++;
        end
        if (!ce) checkOutput("ce_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        ready = 1'b1;
        dlIo  = 1'b0;
        dlW   = 1'b0;
        dlA   = '0;
        dlD   = '0;

        // Reset values
        repeat (3) @(negedge clock32);
        checkOutput("rst_sdrW",   32'(sdrW),   32'd0);
        checkOutput("rst_sdrA",   32'(sdrA),   32'd0);
        checkOutput("rst_sdrD",   32'(sdrD),   32'd0);
        checkOutput("rst_romP",   32'(romP),   32'h07);
        checkOutput("rst_busy",   32'(busy),   32'd0);
        checkOutput("rst_done",   32'(done),   32'd0);
        checkOutput("rst_romA",   32'(romA),   32'd0);
        checkOutput("rst_dlWait0", 32'(dlWait), 32'd0);
        dlIo = 1'b1;
        #1;
        checkOutput("rst_dlWait1", 32'(dlWait), 32'd1);
        dlIo = 1'b0;

        // Full copy straight out of reset
        $display("[TB] full copy after reset");
        reset = 1'b0;
        runCopy(16, 1'b0);
        checkOutput("copy1_writes", 32'(last_writes), 32'd16);
        checkOutput("copy1_ce",     32'(last_ce),     32'd32);
        checkOutput("copy1_done",   32'(done),        32'd1);
        @(negedge clock32);
        checkOutput("copy1_busy",   32'(busy),        32'd0);
        checkOutput("copy1_done2",  32'(done),        32'd1);
        checkOutput("copy1_quiet",  32'(sdrW),        32'd0);

        // Download write after done
        $display("[TB] download after done");
        dlIo = 1'b1;
        #1;
        checkOutput("dl_dlWait", 32'(dlWait), 32'd0);
        applyStimulus(22'h0A4000, 8'h5A);
        checkOutput("dl_sdrW", 32'(sdrW), 32'd1);
        checkOutput("dl_sdrA", 32'(sdrA), 32'h0A4000);
        checkOutput("dl_sdrD", 32'(sdrD), 32'h5A);
        checkOutput("dl_romP", 32'(romP), 32'h29);
        @(negedge clock32);
        checkOutput("dl_sdrW_off",  32'(sdrW), 32'd0);
        checkOutput("dl_sdrA_hold", 32'(sdrA), 32'h0A4000);
        checkOutput("dl_sdrD_hold", 32'(sdrD), 32'h5A);
        dlIo = 1'b0;
        @(negedge clock32);
        checkOutput("dl_romP_hold", 32'(romP), 32'h29);

        // ce and dlW together in DONE
        $display("[TB] ce and dlW together");
        waitCe();
        dlIo = 1'b1;
        applyStimulus(22'h154321, 8'hC3);
        checkOutput("both_sdrW", 32'(sdrW), 32'd1);
        checkOutput("both_sdrA", 32'(sdrA), 32'h154321);
        checkOutput("both_sdrD", 32'(sdrD), 32'hC3);
        checkOutput("both_romP", 32'(romP), 32'h15);
        checkOutput("both_done", 32'(done), 32'd1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock32);
            if (sdrW) pulses++;
        end
        checkOutput("both_extra", 32'(pulses), 32'd0);
        checkOutput("both_done2", 32'(done), 32'd1);
        dlIo = 1'b0;

        // Reset during the WRITE phase of byte 7
        $display("[TB] reset mid-copy");
        reset = 1'b1;
        @(negedge clock32);
        reset = 1'b0;
        runCopy(7, 1'b0);
        waitCe();
        @(negedge clock32);
        checkOutput("mid_romA", 32'(romA), 32'd7);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock32);
            if (sdrW) pulses++;
        end
        checkOutput("mid_pulses", 32'(pulses), 32'd0);
        checkOutput("mid_romP",   32'(romP),   32'h07);
        checkOutput("mid_done",   32'(done),   32'd0);
        reset = 1'b0;
        runCopy(16, 1'b0);
        checkOutput("mid_writes", 32'(last_writes), 32'd16);
        checkOutput("mid_done2",  32'(done),        32'd1);

        // Downloads before done, then a ready drop mid-copy
        $display("[TB] ready drop with download active");
        reset = 1'b1;
        ready = 1'b0;
        dlIo  = 1'b1;
        @(negedge clock32);
        checkOutput("pre_dlWait_rst", 32'(dlWait), 32'd1);
        reset = 1'b0;
        applyStimulus(22'h3FC000, 8'hEE);
        checkOutput("pre_sdrW",   32'(sdrW),   32'd0);
        @(negedge clock32);
        checkOutput("pre_sdrW2",  32'(sdrW),   32'd0);
        checkOutput("pre_romP",   32'(romP),   32'h07);
        checkOutput("pre_dlWait", 32'(dlWait), 32'd1);
        checkOutput("pre_busy",   32'(busy),   32'd0);
        ready = 1'b1;
        runCopy(5, 1'b1);
        ready = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock32);
            if (sdrW) pulses++;
        end
        checkOutput("drop_pulses", 32'(pulses), 32'd0);
        checkOutput("drop_busy",   32'(busy),   32'd0);
        checkOutput("drop_romA",   32'(romA),   32'd0);
        ready = 1'b1;
        runCopy(16, 1'b1);
        checkOutput("drop_writes", 32'(last_writes), 32'd16);
        checkOutput("drop_ce",     32'(last_ce),     32'd32);
        checkOutput("drop_done",   32'(done),        32'd1);
        checkOutput("drop_romP",   32'(romP),        32'h07);
        #1;
        checkOutput("drop_dlWait", 32'(dlWait),      32'd0);

        // ready falling in DONE keeps DONE
        ready = 1'b0;
        repeat (3) @(negedge clock32);
        checkOutput("done_hold", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: SIZE, 17, log2 of internal boot image size in bytes (17 = 128 KB).
REQ-002 clock32  in  1  system clock; all logic rising-edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ready  in  1  SDRAM controller initialised; low = not usable.
REQ-005 ce  in  1  one-cycle pacing strobe (CPU clock enable); consecutive strobes are at least 2 clock32 cycles apart.
REQ-006 romA  out  SIZE  boot ROM byte address.
REQ-007 romQ  in  8  boot ROM data; synchronous, valid 1 cycle after romA.
REQ-008 dlIo  in  1  HPS download active.
REQ-009 dlA  in  22  HPS download byte address.
REQ-010 dlD  in  8  HPS download data.
REQ-011 dlW  in  1  HPS download write strobe, one cycle.
REQ-012 dlWait  out  1  ioctl_wait back-pressure to HPS.
REQ-013 sdrW  out  1  SDRAM write request, one-cycle pulse.
REQ-014 sdrA  out  22  SDRAM byte address.
REQ-015 sdrD  out  8  SDRAM write data.
REQ-016 romP  out  8  highest page (16 KB) holding ROM contents.
REQ-017 busy  out  1  boot copy in progress.
REQ-018 done  out  1  boot copy complete.

Function
REQ-019 States: WAIT (ready low or not yet seen), FETCH, WRITE, DONE.
REQ-020 WAIT -> FETCH on the first clock with ready=1; the byte counter cnt (SIZE bits) is 0.
REQ-021 FETCH: romA=cnt; on ce -> WRITE.
REQ-022 WRITE: on ce, issue a registered pulse: sdrW=1 for exactly one clock, sdrA={zero-extend, cnt}, sdrD=romQ.
REQ-022a On the same ce: if cnt = 2^SIZE-1 -> DONE; otherwise cnt+1 -> FETCH.
REQ-023 Copy cost: exactly 2 ce strobes per byte; 2^(SIZE+1) ce strobes from leaving WAIT to DONE.
REQ-024 busy=1 in FETCH and WRITE; done=1 only in DONE.
REQ-025 ready falling in any state other than DONE -> WAIT, cnt cleared, no sdrW issued; the copy restarts from byte 0.
REQ-026 ready falling in DONE: the block stays in DONE.
REQ-027 dlWait = dlIo AND NOT done.
REQ-028 While not DONE, dlW is ignored: no SDRAM write, no romP change.
REQ-029 In DONE with dlIo=1, each dlW produces, 1 clock later, sdrW=1 for one clock, sdrA=dlA, sdrD=dlD.
REQ-030 In DONE, each dlW with dlIo=1 loads romP <= {2'b00, dlA[19:14]}.
REQ-031 romP retains its value after dlIo falls.
REQ-032 ce and dlW in the same cycle in DONE: dlW is served; ce has no effect in DONE.
REQ-033 sdrA and sdrD hold their last value whenever sdrW=0.
REQ-034 cnt wrap: never wraps; the terminal byte leads to DONE (REQ-022a).

Reset
REQ-035 reset=1 asynchronously forces:
- state=WAIT, cnt=0, romA=0
- sdrW=0, sdrA=0, sdrD=0
- romP=8'h07, busy=0, done=0
REQ-036 dlWait follows REQ-027 during reset (=dlIo).
REQ-037 Reset asserted mid-copy or mid-download: no partial sdrW pulse; the next copy starts from byte 0 after reset is released and ready=1.

Verification (SIZE=4, ROM byte n = 8'hA0+n, ce every 4 clocks)
REQ-038 Release reset with ready=1 -> 16 sdrW pulses, addresses 0..15 in order, data A0..AF; done=1 after the 32nd ce; busy=0 afterwards.
REQ-039 Drop ready for 3 clocks after the 5th sdrW, then restore -> writes restart at address 0; 16 further pulses; done=1.
REQ-040 dlIo=1 before done -> dlWait=1 and any dlW produces no sdrW; after done -> dlWait=0.
REQ-041 After done: dlW with dlA=22'h0A4000, dlD=8'h5A -> next clock sdrW=1, sdrA=22'h0A4000, sdrD=5A; romP=8'h29.
REQ-042 Assert reset during the WRITE phase of byte 7 -> sdrW stays 0, romP=8'h07, done=0; after release, addresses 0..15 are rewritten.
REQ-043 After done: ce and dlW in the same cycle -> exactly one sdrW carrying the download data; state remains DONE.
